open_riscv_soc: RTL and testbench
=================================

Name: open_riscv_soc

Overview:
- Minimal single-cycle RV32I SoC: instruction ROM, integer core and a 32x32 register file, all in one clock domain.
- Top level of the CPU subsystem. Programs are preloaded into the ROM array by simulation/synthesis init; there is no external bus.
- Used for riscv-tests style self-checking programs. By convention x26=1 means done, x27=1 means pass, and x3 holds the test number.

Parameters:
- ROM_DEPTH, 4096, number of 32-bit instruction words in the ROM.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.

Behaviour:
- Hierarchy is fixed, because benches probe it:
  - core instance open_risc_v_inst, containing regfile instance regs_inst with array regs[0:31] of 32-bit values.
  - ROM instance rom_inst, containing array rom_mem[0:ROM_DEPTH-1] of 32-bit words.
- Reset (rst=1 at a rising clk edge): PC<=RESET_PC and regs[1..31]<=0. regs[0] is always 0. ROM contents are not affected by reset.
- Fetch: ROM read is combinational. Instruction = rom_mem[pc[31:2]]. An index >= ROM_DEPTH returns 32'h0000_0013 (NOP).
- Execution is single-cycle: decode, register read, ALU and next-PC are combinational. Register write and PC update happen on the same rising edge. Each instruction retires exactly one cycle after it is fetched.
- Regfile:
  - Two combinational read ports and one write port.
  - Writes to x0 are ignored.
  - Read-during-write in the same cycle returns the old value; a single-cycle core never needs bypass.
- Supported instructions (all others, including FENCE, ECALL, EBREAK, CSR*, loads and stores, execute as NOP with PC+4):
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic rules:
  - 32-bit wraparound; no overflow traps.
  - Shift amount is rs2[4:0] or shamt[4:0].
  - SRA/SRAI replicate bit 31.
  - SLT/SLTI are signed compares; SLTU/SLTIU are unsigned. SLTIU sign-extends the immediate, then compares unsigned.
  - All immediates are sign-extended per the RV32I encodings.
- Control flow:
  - Branch taken: PC<=PC+B-imm; not taken: PC+4.
  - JAL: rd<=PC+4, PC<=PC+J-imm.
  - JALR: rd<=PC+4, PC<=(rs1+imm)&~1, using the rs1 value read before the write. rd==rs1 is therefore safe.
  - Fetch ignores pc[1:0]; no misalignment exception.
- rst asserted mid-program: at the next edge the PC returns to RESET_PC and registers clear. Execution restarts from RESET_PC once rst deasserts.

Optional Feature:
- Macro TRACE_PRINT_EN.
- Defined: on every non-reset rising edge, a simulation-only $display prints PC, instruction word, and (if rd!=0 and a write occurs) rd index and write value. It is non-synthesizable and excluded from synthesis.
- Undefined: no display statements; RTL is identical otherwise.

Test Plan:
- Reset: hold rst=1 for 2 cycles, ROM all NOP -> PC=0, regs[1..31]=0. After release, PC increments by 4 each cycle: 4, 8, 12.
- ALU/shift:
  - addi x1,x0,-16; srai x2,x1,2; srli x3,x1,28; sub x4,x0,x1 -> x1=0xFFFFFFF0, x2=0xFFFFFFFC, x3=0xF, x4=16.
  - sra x5,x1,x6 with x6=0x24 -> only shamt 4 is used, x5=0xFFFFFFFF.
- x0 and compares:
  - addi x0,x0,5 -> x0 stays 0.
  - slt x7,x1,x0 -> 1; sltu x8,x1,x0 -> 0; sltiu x9,x0,-1 -> 1.
- Branch/jump:
  - Taken beq skips the next instruction.
  - jal x1,+8 at PC 0x20 -> x1=0x24, PC=0x28.
  - jalr x1,x1,1 with x1=0x40 -> PC=0x40, x1=return address.
  - lui x10,0x12345 -> 0x12345000; auipc at PC 0x10 with imm 1 -> 0x1010.
- Self-check program: load an rv32ui-p style image (e.g. sra) into rom_mem, run from reset -> x26 becomes 1. 200 ns later x27==1; on failure, x3 reports the failing test number.
- Mid-run reset: assert rst for 1 cycle while PC=0x30 -> PC=0, registers cleared, program reruns to the same final register state.

Source files
------------

// File: rtl/open_riscv_soc.sv
// Single-cycle RV32I SoC: combinational instruction ROM, integer core and 32x32 register file.
// Define TRACE_PRINT_EN to get a simulation-only per-retirement trace line.

module open_riscv_soc_rom #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic [29:0] word_idx,
    output logic [31:0] instr
);
    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    always_comb begin
        instr = NOP;
        if ({2'b00, word_idx} < 32'(ROM_DEPTH)) begin
            instr = rom_mem[word_idx[AW-1:0]];
        end
    end
endmodule

module open_riscv_soc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    // Reads see the pre-edge contents; the single-cycle core never needs bypass.
    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end
endmodule

module open_risc_v #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [29:0] fetch_idx
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, imm_b, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res;
    logic signed [31:0] alu_a_s, alu_b_s, sra_res;
    logic        funct7_ok, alu_ok, br_taken;
    logic        rd_we;
    logic [31:0] rd_wdata;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_u     = {instr[31:12], 12'h000};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign fetch_idx = pc_q[31:2];
    assign pc_plus4  = pc_q + 32'd4;

    open_riscv_soc_regfile regs_inst (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (rd_we),
        .wa  (rd),
        .wd  (rd_wdata)
    );

    // Shared ALU for OP and OP-IMM; funct7 bit 30 selects SUB/SRA only where legal.
    always_comb begin
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_a_s = rs1_val;
        alu_b_s = alu_b;
        sra_res = alu_a_s >>> shamt;
        alu_res = 32'd0;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'd0, alu_a_s < alu_b_s};
            3'b011: alu_res = {31'd0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = instr[30] ? sra_res : (rs1_val >> shamt);
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Encodings outside the supported funct7 space (e.g. M-extension) retire as NOP.
    always_comb begin
        funct7_ok = (funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'b101 || (opcode == OPC_OP && funct3 == 3'b000)));
        if (opcode == OPC_OP) begin
            alu_ok = funct7_ok;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
            alu_ok = funct7_ok;
        end else begin
            alu_ok = 1'b1;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = !($signed(rs1_val) < $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = !(rs1_val < rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = alu_res;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OPC_OPIMM, OPC_OP: begin
                rd_we = alu_ok;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef TRACE_PRINT_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            if (rd_we && rd != 5'd0) begin
                $display("trace pc=%08h instr=%08h x%0d=%08h", pc_q, instr, rd, rd_wdata);
            end else begin
                $display("trace pc=%08h instr=%08h", pc_q, instr);
            end
        end
    end
`endif
`endif
endmodule

module open_riscv_soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    logic [29:0] fetch_idx;
    logic [31:0] instr;

    open_riscv_soc_rom #(
        .ROM_DEPTH (ROM_DEPTH)
    ) rom_inst (
        .word_idx (fetch_idx),
        .instr    (instr)
    );

    open_risc_v #(
        .RESET_PC (RESET_PC)
    ) open_risc_v_inst (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .fetch_idx (fetch_idx)
    );
endmodule

// File: tb/tb_open_riscv_soc.sv
// Bench for open_riscv_soc: directed programs plus random programs checked against an ISA-level model.
module tb_open_riscv_soc;
    localparam int ROM_DEPTH  = 4096;
    localparam int PROG_WORDS = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OPI = 32'h13, OPR = 32'h33, LUI = 32'h37, AUIPC = 32'h17, JALR = 32'h67;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [31:0] prog [0:PROG_WORDS-1];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;
    logic [31:0] sc_q [$];

    open_riscv_soc #(.ROM_DEPTH(ROM_DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                          logic [31:0] rd, logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] off, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] off, logic [31:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] dut_reg(int i);
        return dut.open_risc_v_inst.regs_inst.regs[i];
    endfunction

    function automatic logic [31:0] dut_pc();
        return dut.open_risc_v_inst.pc_q;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < PROG_WORDS; i++) prog[i] = NOP;
    endtask

    task automatic load_prog();
        for (int i = 0; i < ROM_DEPTH; i++) begin
            dut.rom_inst.rom_mem[i] = (i < PROG_WORDS) ? prog[i] : NOP;
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        step(cycles);
        rst = 1'b0;
    endtask

    // ISA-level reference: one call retires one instruction from prog[].
    task automatic model_step();
        int idx;
        logic [31:0] ins, a, b, b2, iimm, bimm, jimm, uimm, val, nxt;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] sa;
        logic [4:0] rd, sh;
        logic [2:0] f3;
        logic [6:0] f7;
        bit wr, take, reg_op, base_ok;
        idx  = int'(m_pc >> 2);
        ins  = (idx < PROG_WORDS) ? prog[idx] : NOP;
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        i12  = ins[31:20];
        b13  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        iimm = i12;
        bimm = b13;
        jimm = j21;
        uimm = ins[31:12] * 32'd4096;
        f3 = ins[14:12];
        f7 = ins[31:25];
        rd = ins[11:7];
        wr = 0;
        val = 0;
        take = 0;
        nxt = m_pc + 4;
        case (ins[6:0])
            7'h37: begin wr = 1; val = uimm; end
            7'h17: begin wr = 1; val = m_pc + uimm; end
            7'h6f: begin wr = 1; val = m_pc + 4; nxt = m_pc + jimm; end
            7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; nxt = (a + iimm) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) < $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a < b);
                    3'd7: take = (a >= b);
                    default: take = 0;
                endcase
                if (take) nxt = m_pc + bimm;
            end
            7'h13, 7'h33: begin
                reg_op  = (ins[6:0] == 7'h33);
                b2      = reg_op ? b : iimm;
                sh      = b2[4:0];
                base_ok = !reg_op || (f7 == 0);
                case (f3)
                    3'd0: begin
                        if (base_ok) begin wr = 1; val = a + b2; end
                        else if (f7 == 7'h20) begin wr = 1; val = a - b2; end
                    end
                    3'd1: if (f7 == 0) begin wr = 1; val = a << sh; end
                    3'd2: begin wr = base_ok; val = ($signed(a) < $signed(b2)) ? 32'd1 : 32'd0; end
                    3'd3: begin wr = base_ok; val = (a < b2) ? 32'd1 : 32'd0; end
                    3'd4: begin wr = base_ok; val = a ^ b2; end
                    3'd6: begin wr = base_ok; val = a | b2; end
                    3'd7: begin wr = base_ok; val = a & b2; end
                    default: begin
                        if (f7 == 0) begin wr = 1; val = a >> sh; end
                        else if (f7 == 7'h20) begin wr = 1; sa = a; sa = sa >>> sh; val = sa; end
                    end
                endcase
            end
            default: ;
        endcase
        if (wr && rd != 0) m_regs[rd] = val;
        m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    function automatic logic [31:0] rand_instr(bit with_branch);
        logic [31:0] rd, rs1, rs2, f3, f7, imm;
        logic [2:0] bf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        rs2 = $urandom_range(0, 15);
        f3  = $urandom_range(0, 7);
        imm = $urandom;
        case ($urandom_range(0, 9))
            0, 1: begin
                f7 = 0;
                if ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) f7 = 32'h20;
                if ($urandom_range(0, 7) == 0) f7 = 32'h01;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            2, 3, 4: begin
                if (f3 == 1) imm[11:5] = 7'h00;
                if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, OPI);
            end
            5: return enc_u(imm, rd, LUI);
            6: return enc_u(imm, rd, AUIPC);
            7: begin
                if (with_branch) return enc_b(8, rs2, rs1, {29'd0, bf[$urandom_range(0, 5)]});
                return enc_i(imm, rs1, 0, rd, OPI);
            end
            8: return enc_i(imm, rs1, f3, rd, 32'h03);
            default: return {imm[31:7], 7'h23};
        endcase
    endfunction

    task automatic gen_random(bit with_branch);
        clear_prog();
        for (int i = 0; i < 40; i++) prog[i] = rand_instr(with_branch);
    endtask

    task automatic push_li(logic [31:0] rd, logic [31:0] val);
        logic [31:0] hi;
        hi = (val + 32'h800) >> 12;
        sc_q.push_back(enc_u(hi, rd, LUI));
        sc_q.push_back(enc_i(val, rd, 0, rd, OPI));
    endtask

    task automatic test_reset();
        clear_prog();
        for (int i = 1; i < 32; i++) prog[i-1] = enc_i(i, 0, 0, i, OPI);
        load_prog();
        do_reset(2);
        step(31);
        clear_prog();
        load_prog();
        do_reset(2);
        checks++;
        if (dut_pc() !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc: got %08h expected %08h", dut_pc(), 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== 32'h0) begin
                failures++;
                $display("FAIL reset_x%0d: got %08h expected 00000000", i, dut_reg(i));
            end
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (dut_pc() !== 32'(4 * k)) begin
                failures++;
                $display("FAIL nop_pc_%0d: got %08h expected %08h", k, dut_pc(), 32'(4 * k));
            end
        end
    endtask

    task automatic test_alu_shift();
        int          ri [6] = '{1, 2, 3, 4, 5, 6};
        logic [31:0] ev [6] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'h0000_000F, 32'h10, 32'hFFFF_FFFF, 32'h24};
        clear_prog();
        prog[0] = enc_i(-16, 0, 0, 1, OPI);
        prog[1] = enc_i(32'h402, 1, 5, 2, OPI);
        prog[2] = enc_i(28, 1, 5, 3, OPI);
        prog[3] = enc_r(32'h20, 1, 0, 0, 4);
        prog[4] = enc_i(32'h24, 0, 0, 6, OPI);
        prog[5] = enc_r(32'h20, 6, 1, 5, 5);
        load_prog();
        do_reset(2);
        step(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut_reg(ri[i]) !== ev[i]) begin
                failures++;
                $display("FAIL alu_x%0d: got %08h expected %08h", ri[i], dut_reg(ri[i]), ev[i]);
            end
        end
    endtask

    task automatic test_x0_compare();
        int          ri [4] = '{0, 7, 8, 9};
        logic [31:0] ev [4] = '{32'h0, 32'h1, 32'h0, 32'h1};
        clear_prog();
        prog[0] = enc_i(5, 0, 0, 0, OPI);
        prog[1] = enc_i(-16, 0, 0, 1, OPI);
        prog[2] = enc_r(0, 0, 1, 2, 7);
        prog[3] = enc_r(0, 0, 1, 3, 8);
        prog[4] = enc_i(-1, 0, 3, 9, OPI);
        load_prog();
        do_reset(2);
        step(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_reg(ri[i]) !== ev[i]) begin
                failures++;
                $display("FAIL cmp_x%0d: got %08h expected %08h", ri[i], dut_reg(ri[i]), ev[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        int          ri [5] = '{2, 3, 4, 10, 11};
        logic [31:0] ev [5] = '{32'h2, 32'h0, 32'h7, 32'h1234_5000, 32'h0000_1010};
        clear_prog();
        prog[0]  = enc_i(1, 0, 0, 2, OPI);
        prog[1]  = enc_b(8, 2, 2, 0);
        prog[2]  = enc_i(99, 0, 0, 3, OPI);
        prog[3]  = enc_i(7, 0, 0, 4, OPI);
        prog[4]  = enc_u(1, 11, AUIPC);
        prog[5]  = enc_u(32'h12345, 10, LUI);
        prog[6]  = enc_i(32'h40, 0, 0, 5, OPI);
        prog[8]  = enc_j(8, 1);
        prog[9]  = enc_i(55, 0, 0, 3, OPI);
        prog[10] = enc_i(32'h40, 0, 0, 1, OPI);
        prog[11] = enc_i(1, 1, 0, 1, JALR);
        prog[16] = enc_i(2, 0, 0, 2, OPI);
        prog[17] = enc_u(4, 12, LUI);
        prog[18] = enc_i(0, 12, 0, 0, JALR);
        load_prog();
        do_reset(2);
        step(8);
        checks++;
        if (dut_pc() !== 32'h28 || dut_reg(1) !== 32'h24) begin
            failures++;
            $display("FAIL jal: got pc=%08h x1=%08h expected pc=00000028 x1=00000024", dut_pc(), dut_reg(1));
        end
        step(2);
        checks++;
        if (dut_pc() !== 32'h40 || dut_reg(1) !== 32'h30) begin
            failures++;
            $display("FAIL jalr: got pc=%08h x1=%08h expected pc=00000040 x1=00000030", dut_pc(), dut_reg(1));
        end
        step(4);
        checks++;
        if (dut_pc() !== 32'h4004) begin
            failures++;
            $display("FAIL rom_oob_pc: got %08h expected 00004004", dut_pc());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(ri[i]) !== ev[i]) begin
                failures++;
                $display("FAIL br_x%0d: got %08h expected %08h", ri[i], dut_reg(ri[i]), ev[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            gen_random(1);
            load_prog();
            model_reset();
            do_reset(1);
            for (int s = 0; s < 44; s++) begin
                step(1);
                model_step();
                checks++;
                if (dut_pc() !== m_pc) begin
                    failures++;
                    $display("FAIL rand%0d_pc_step%0d: got %08h expected %08h", r, s, dut_pc(), m_pc);
                end
            end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (dut_reg(i) !== m_regs[i]) begin
                    failures++;
                    $display("FAIL rand%0d_x%0d: got %08h expected %08h", r, i, dut_reg(i), m_regs[i]);
                end
            end
        end
    endtask

    task automatic test_selfcheck();
        logic [31:0] av, sv, ev;
        logic signed [31:0] as_v;
        int waited;
        bit done;
        sc_q.delete();
        for (int t = 2; t <= 6; t++) begin
            av = $urandom;
            sv = $urandom;
            if (t == 2) begin av = 32'h8000_0000; sv = 32'h24; end
            as_v = av;
            as_v = as_v >>> sv[4:0];
            ev = as_v;
            push_li(3, t);
            push_li(1, av);
            push_li(2, sv);
            sc_q.push_back(enc_r(32'h20, 2, 1, 5, 14));
            push_li(29, ev);
            sc_q.push_back(enc_b(800 - 4 * sc_q.size(), 29, 14, 1));
        end
        sc_q.push_back(enc_i(1, 0, 0, 27, OPI));
        sc_q.push_back(enc_i(1, 0, 0, 26, OPI));
        sc_q.push_back(enc_j(0, 0));
        clear_prog();
        foreach (sc_q[i]) prog[i] = sc_q[i];
        prog[200] = enc_i(1, 0, 0, 26, OPI);
        prog[201] = enc_j(0, 0);
        load_prog();
        do_reset(2);
        done = 0;
        waited = 0;
        while (!done && waited < 2000) begin
            step(1);
            waited++;
            if (dut_reg(26) === 32'h1) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL selfcheck_done: x26 never reached 1 within %0d cycles", waited);
        end
        #200;
        checks++;
        if (dut_reg(27) !== 32'h1 || dut_reg(3) !== 32'd6) begin
            failures++;
            $display("FAIL selfcheck_pass: got x27=%08h x3=%0d expected x27=00000001 x3=6", dut_reg(27), dut_reg(3));
        end
    endtask

    task automatic test_midrun_reset();
        gen_random(0);
        load_prog();
        model_reset();
        for (int s = 0; s < 44; s++) model_step();
        do_reset(1);
        step(12);
        checks++;
        if (dut_pc() !== 32'h30) begin
            failures++;
            $display("FAIL midrun_pc_before: got %08h expected 00000030", dut_pc());
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (dut_pc() !== 32'h0) begin
            failures++;
            $display("FAIL midrun_pc_reset: got %08h expected 00000000", dut_pc());
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== 32'h0) begin
                failures++;
                $display("FAIL midrun_clear_x%0d: got %08h expected 00000000", i, dut_reg(i));
            end
        end
        step(44);
        checks++;
        if (dut_pc() !== m_pc) begin
            failures++;
            $display("FAIL midrun_final_pc: got %08h expected %08h", dut_pc(), m_pc);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== m_regs[i]) begin
                failures++;
                $display("FAIL midrun_final_x%0d: got %08h expected %08h", i, dut_reg(i), m_regs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_shift();
        test_x0_compare();
        test_branch_jump();
        test_random();
        test_selfcheck();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
